// File: rtl/i2s_tx.sv
// I2S master transmitter: derives SCK/WS from clk and serialises stereo PCM
// samples MSB-first onto SD, one SCK after each WS edge. A one-entry holding
// register accepts sample pairs on a valid/ready handshake.
module i2s_tx #(
   parameter int unsigned W         = 16,
   parameter int unsigned SLOT_BITS = 32,
   parameter int unsigned CLK_DIV   = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] s_l_data,
   input  logic [W-1:0] s_r_data,
   input  logic         s_valid,
   output logic         s_ready,
   output logic         i2s_sck,
   output logic         i2s_ws,
   output logic         i2s_sd,
   output logic         frame_start,
   output logic         underrun
);

   localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
   localparam int unsigned BW         = $clog2(FRAME_BITS);
   localparam int unsigned DW         = $clog2(CLK_DIV);
   localparam logic [BW-1:0] B_LAST   = BW'(FRAME_BITS - 1);
   localparam logic [BW-1:0] B_SLOT   = BW'(SLOT_BITS);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [BW-1:0] b_q, b_d;
   logic          sck_q, sck_d;
   logic          ws_q, ws_d;
   logic          sd_q, sd_d;
   logic          hold_full_q, hold_full_d;
   logic [W-1:0]  hold_l_q, hold_l_d;
   logic [W-1:0]  hold_r_q, hold_r_d;
   logic [W-1:0]  shl_q, shl_d;
   logic [W-1:0]  shr_q, shr_d;
   logic          fs_q, fs_d;
   logic          ur_q, ur_d;
   logic          rdy_q, rdy_d;

   logic [BW-1:0] b_nx;
   logic [BW-1:0] b_nx_p1;

   // Next-state: clock divider, bit sequencing, frame load and holding register
   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      b_d         = b_q;
      sck_d       = sck_q;
      ws_d        = ws_q;
      sd_d        = sd_q;
      hold_full_d = hold_full_q;
      hold_l_d    = hold_l_q;
      hold_r_d    = hold_r_q;
      shl_d       = shl_q;
      shr_d       = shr_q;
      fs_d        = 1'b0;
      ur_d        = 1'b0;

      b_nx    = (b_q == B_LAST) ? '0 : b_q + BW'(1);
      b_nx_p1 = (b_nx == B_LAST) ? '0 : b_nx + BW'(1);

      case (state_q)
         ST_IDLE: begin
            sck_d = 1'b0;
            ws_d  = 1'b0;
            sd_d  = 1'b0;
            div_d = '0;
            if (en) begin
               state_d = ST_RUN;
               b_d     = B_LAST;
            end
         end
         ST_RUN: begin
            if (div_q == DIV_LAST) begin
               div_d = '0;
               sck_d = !sck_q;
               if (sck_q) begin
                  // Fall tick: advance to the next frame bit
                  if ((b_q == B_LAST) && !en) begin
                     state_d = ST_IDLE;
                     sck_d   = 1'b0;
                     ws_d    = 1'b0;
                     sd_d    = 1'b0;
                  end else begin
                     b_d  = b_nx;
                     ws_d = (b_nx_p1 >= B_SLOT);
                     if (b_q == B_LAST) begin
                        fs_d = 1'b1;
                        if (hold_full_q) begin
                           sd_d        = hold_l_q[W-1];
                           shl_d       = hold_l_q << 1;
                           shr_d       = hold_r_q;
                           hold_full_d = 1'b0;
                        end else begin
                           sd_d  = 1'b0;
                           shl_d = '0;
                           shr_d = '0;
                           ur_d  = 1'b1;
                        end
                     end else if (b_nx < B_SLOT) begin
                        sd_d  = shl_q[W-1];
                        shl_d = shl_q << 1;
                     end else begin
                        sd_d  = shr_q[W-1];
                        shr_d = shr_q << 1;
                     end
                  end
               end
            end else begin
               div_d = div_q + DW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A load and an accept never coincide: ready is low while full
      if (s_valid && rdy_q) begin
         hold_full_d = 1'b1;
         hold_l_d    = s_l_data;
         hold_r_d    = s_r_data;
      end
      rdy_d = !hold_full_d;
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         div_q       <= '0;
         b_q         <= '0;
         sck_q       <= 1'b0;
         ws_q        <= 1'b0;
         sd_q        <= 1'b0;
         hold_full_q <= 1'b0;
         hold_l_q    <= '0;
         hold_r_q    <= '0;
         shl_q       <= '0;
         shr_q       <= '0;
         fs_q        <= 1'b0;
         ur_q        <= 1'b0;
         rdy_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         b_q         <= b_d;
         sck_q       <= sck_d;
         ws_q        <= ws_d;
         sd_q        <= sd_d;
         hold_full_q <= hold_full_d;
         hold_l_q    <= hold_l_d;
         hold_r_q    <= hold_r_d;
         shl_q       <= shl_d;
         shr_q       <= shr_d;
         fs_q        <= fs_d;
         ur_q        <= ur_d;
         rdy_q       <= rdy_d;
      end
   end

   assign s_ready     = rdy_q;
   assign i2s_sck     = sck_q;
   assign i2s_ws      = ws_q;
   assign i2s_sd      = sd_q;
   assign frame_start = fs_q;
   assign underrun    = ur_q;

endmodule
